home_inventory_adc_frame_fifo: RTL and testbench

- Parametrised ADC frame buffer that replaces the fixed 8-channel, 16-deep stub FIFO in the bring-up register block.
- Accepts whole ADC frames from the capture path and serialises each into a power-of-2 FIFO as a status word followed by CH0..CH(NUM_CH-1).
- A Wishbone slave window lets firmware drain the FIFO (read-to-pop), set a watermark and flush.
- Adds atomic frame drop on overrun, a frame sequence number, a drop counter and a level-watermark IRQ.

---
 rtl/home_inventory_adc_frame_fifo_if.sv | 42 ++++
 rtl/home_inventory_adc_frame_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_home_inventory_adc_frame_fifo.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/home_inventory_adc_frame_fifo_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : home_inventory_adc_frame_fifo_if                              |
// | Purpose  : Bundles the Wishbone slave window and the ADC frame handshake |
// |            of the frame FIFO into one interface.                         |
// | Ports    : wbs_* - Wishbone classic slave signals                        |
// |            frame_valid/frame_data/frame_ready - whole-frame handshake    |
// |            irq_o - level-sensitive watermark interrupt                   |
// | Modports : slave  - the FIFO block                                       |
// |            master - firmware bus / capture path side                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface home_inventory_adc_frame_fifo_if #(
  parameter int NUM_CH = 8
);
  logic                    wbs_stb_i;
  logic                    wbs_cyc_i;
  logic                    wbs_we_i;
  logic [3:0]              wbs_sel_i;
  logic [31:0]             wbs_dat_i;
  logic [31:0]             wbs_adr_i;
  logic                    wbs_ack_o;
  logic [31:0]             wbs_dat_o;
  logic                    frame_valid;
  logic [32*NUM_CH-1:0]    frame_data;
  logic                    frame_ready;
  logic                    irq_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  frame_valid, frame_data,
    output wbs_ack_o, wbs_dat_o, frame_ready, irq_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output frame_valid, frame_data,
    input  wbs_ack_o, wbs_dat_o, frame_ready, irq_o
  );
endinterface
`default_nettype wire

// File: rtl/home_inventory_adc_frame_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : home_inventory_adc_frame_fifo                                 |
// | Purpose  : ADC frame buffer. Each accepted frame is serialised into a    |
// |            power-of-2 word FIFO as a status word followed by CH0..CHn-1. |
// |            Firmware drains it through a 16-byte Wishbone window.         |
// |            Frames that do not fit are dropped whole and counted.         |
// | Ports    : wb_clk_i - clock                                             |
// |            wb_rst_i - asynchronous active-high reset                     |
// |            bus      - slave modport: Wishbone window, frame handshake,   |
// |                       watermark irq                                      |
// | Regs     : 0x0 FIFO_DATA (RO, read pops), 0x4 STATUS, 0x8 CTRL,          |
// |            0xC DROP_COUNT                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module home_inventory_adc_frame_fifo #(
  parameter int          NUM_CH   = 8,
  parameter int          DEPTH    = 32,
  parameter logic [31:0] BASE_ADR = 32'h3000_0100
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rst_i,
  home_inventory_adc_frame_fifo_if.slave       bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_WRITE = 1'b1;

  // ---------------------------------------------------------------- state
  logic [0:0]           r_state;
  logic [3:0]           r_idx;
  logic [32*NUM_CH-1:0] r_frame;
  logic [31:0]          r_status;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_level;
  logic                 r_overrun;
  logic [15:0]          r_seq;
  logic [7:0]           r_drop_since;
  logic [31:0]          r_drop_cnt;
  logic [15:0]          r_wm;
  logic                 r_flush;
  logic                 r_irq;
  logic                 r_ack;
  logic [31:0]          r_dat;
  logic [31:0]          r_mem [DEPTH];

  // ---------------------------------------------------------------- decode
  logic        w_hit;
  logic        w_fire;
  logic        w_rd;
  logic        w_wr;
  logic [1:0]  w_off;
  logic        w_take;
  logic        w_room;
  logic        w_push;
  logic        w_pop;
  logic        w_flush_req;
  logic        w_ovr_clr;
  logic [15:0] w_seq_next;
  logic [31:0] w_level32;
  logic [3:0]  w_ch_sel;
  logic [31:0] w_push_data;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_hit   = (bus.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_fire  = bus.wbs_cyc_i & bus.wbs_stb_i & w_hit & ~r_ack;
  assign w_rd    = w_fire & ~bus.wbs_we_i;
  assign w_wr    = w_fire &  bus.wbs_we_i;
  assign w_off   = bus.wbs_adr_i[3:2];

  assign w_level32 = 32'(r_level);
  assign w_take    = bus.frame_valid & (r_state == c_IDLE);
  // Room is judged only at take time; later pops can only add space.
  assign w_room    = (32'(DEPTH) - w_level32) >= 32'(NUM_CH + 1);

  // A pending flush suppresses same-cycle push/pop so the flush wins.
  assign w_push      = (r_state == c_WRITE) & ~r_flush;
  assign w_pop       = w_rd & (w_off == 2'd0) & (r_level != '0) & ~r_flush;
  assign w_flush_req = w_wr & (w_off == 2'd2) & bus.wbs_sel_i[3] & bus.wbs_dat_i[31];
  assign w_ovr_clr   = w_wr & (w_off == 2'd1) & bus.wbs_sel_i[2] & bus.wbs_dat_i[16];
  assign w_seq_next  = r_seq + 16'd1;
  assign w_ch_sel    = r_idx - 4'd1;

  assign w_unused = ^{bus.wbs_adr_i[1:0], bus.wbs_dat_i[30:17]};

  always_comb begin
    w_push_data = r_status;
    if (r_idx != 4'd0) begin
      w_push_data = r_frame[32*w_ch_sel +: 32];
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      2'd0: w_rdata = (r_level != '0) ? r_mem[r_rd_ptr] : 32'd0;
      2'd1: w_rdata = {13'd0, (r_state == c_WRITE), r_irq, r_overrun, w_level32[15:0]};
      2'd2: w_rdata = {16'd0, r_wm};
      2'd3: w_rdata = r_drop_cnt;
      default: w_rdata = 32'd0;
    endcase
  end

  // Storage array carries no reset; only pointers define valid contents.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= c_IDLE;
      r_idx        <= 4'd0;
      r_frame      <= '0;
      r_status     <= 32'd0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_overrun    <= 1'b0;
      r_seq        <= 16'd0;
      r_drop_since <= 8'd0;
      r_drop_cnt   <= 32'd0;
      r_wm         <= 16'd0;
      r_flush      <= 1'b0;
      r_irq        <= 1'b0;
      r_ack        <= 1'b0;
      r_dat        <= 32'd0;
    end else begin
      // ---------------- Wishbone window
      r_ack   <= w_fire;
      r_flush <= w_flush_req;
      if (w_rd) begin
        r_dat <= w_rdata;
      end
      if (w_wr && (w_off == 2'd2)) begin
        if (bus.wbs_sel_i[0]) r_wm[7:0]  <= bus.wbs_dat_i[7:0];
        if (bus.wbs_sel_i[1]) r_wm[15:8] <= bus.wbs_dat_i[15:8];
      end

      r_irq <= (r_wm != 16'd0) && (w_level32 >= 32'(r_wm));

      // A new drop in the same cycle as a W1C keeps the flag set.
      if (w_take && !w_room) begin
        r_overrun <= 1'b1;
      end else if (w_ovr_clr) begin
        r_overrun <= 1'b0;
      end

      // ---------------- frame FSM
      case (r_state)
        c_IDLE: begin
          if (w_take) begin
            if (w_room) begin
              r_frame      <= bus.frame_data;
              r_status     <= {w_seq_next, r_drop_since, 8'(NUM_CH)};
              r_seq        <= w_seq_next;
              r_drop_since <= 8'd0;
              r_idx        <= 4'd0;
              r_state      <= c_WRITE;
            end else begin
              if (r_drop_cnt != 32'hFFFF_FFFF) r_drop_cnt   <= r_drop_cnt + 32'd1;
              if (r_drop_since != 8'hFF)       r_drop_since <= r_drop_since + 8'd1;
            end
          end
        end
        c_WRITE: begin
          if (r_flush || (r_idx == 4'(NUM_CH))) begin
            r_state <= c_IDLE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase

      // ---------------- pointers / level
      if (r_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  assign bus.wbs_ack_o   = r_ack;
  assign bus.wbs_dat_o   = r_dat;
  assign bus.frame_ready = (r_state == c_IDLE);
  assign bus.irq_o       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_home_inventory_adc_frame_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_home_inventory_adc_frame_fifo                              |
// | Purpose  : Self-checking bench for the ADC frame FIFO (NUM_CH=8,         |
// |            DEPTH=32): register table, overrun/drop, W1C, watermark irq,  |
// |            flush mid-frame, pointer wrap and reset mid-frame.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_home_inventory_adc_frame_fifo;

  localparam int          NUM_CH = 8;
  localparam int          DEPTH  = 32;
  localparam logic [31:0] BASE   = 32'h3000_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  home_inventory_adc_frame_fifo_if #(.NUM_CH(NUM_CH)) bus ();

  home_inventory_adc_frame_fifo #(
    .NUM_CH   (NUM_CH),
    .DEPTH    (DEPTH),
    .BASE_ADR (BASE)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    bit          we;
    logic [3:0]  off;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'd0;
    bus.wbs_adr_i = 32'd0;
  endtask

  task automatic wb_rw(input bit we, input logic [3:0] off, input logic [31:0] wdata,
                       input logic [3:0] sel, output logic [31:0] rdata);
    int waited;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_dat_i = wdata;
    bus.wbs_adr_i = BASE + {28'd0, off};
    @(posedge clk); #1;
    waited = 0;
    while (!bus.wbs_ack_o && waited < 4) begin
      @(posedge clk); #1;
      waited++;
    end
    check("wb_ack", {31'd0, bus.wbs_ack_o}, 32'd1);
    rdata = bus.wbs_dat_o;
    bus_idle();
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] rdata);
    wb_rw(1'b0, off, 32'd0, 4'hF, rdata);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] wdata, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_rw(1'b1, off, wdata, sel, dummy);
  endtask

  // Offers one frame (CHk = base+k) and returns edges until frame_ready is back.
  task automatic push_frame(input logic [31:0] base, output int n);
    @(negedge clk);
    bus.frame_valid = 1'b1;
    for (int k = 0; k < NUM_CH; k++) bus.frame_data[32*k +: 32] = base + 32'(k);
    @(posedge clk); #1;
    bus.frame_valid = 1'b0;
    n = 0;
    while (!bus.frame_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("frame_ready_return", {31'd0, bus.frame_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    bus.frame_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    int          got;
    int          tries;

    rst = 1'b1;
    bus_idle();
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   {31'd0, bus.wbs_ack_o},   32'd0);
    check("rst_dat",   bus.wbs_dat_o,            32'd0);
    check("rst_ready", {31'd0, bus.frame_ready}, 32'd1);
    check("rst_irq",   {31'd0, bus.irq_o},       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- single frame + register table
    push_frame(32'h0000_0100, n);
    check("ready_latency", n, NUM_CH + 1);

    vecs[0] = '{1'b0, 4'h4, 32'd0, 4'hF, 32'd9};
    vecs[1] = '{1'b0, 4'h0, 32'd0, 4'hF, 32'h0001_0008};
    for (int k = 0; k < 8; k++) vecs[2+k] = '{1'b0, 4'h0, 32'd0, 4'hF, 32'h100 + 32'(k)};
    vecs[10] = '{1'b0, 4'h4, 32'd0,          4'hF, 32'd0};
    vecs[11] = '{1'b0, 4'h0, 32'd0,          4'hF, 32'd0};
    vecs[12] = '{1'b0, 4'h6, 32'd0,          4'hF, 32'd0};
    vecs[13] = '{1'b1, 4'h8, 32'h0000_1234,  4'h3, 32'd0};
    vecs[14] = '{1'b0, 4'h8, 32'd0,          4'hF, 32'h0000_1234};
    vecs[15] = '{1'b1, 4'h8, 32'hFFFF_FFAB,  4'h1, 32'd0};
    vecs[16] = '{1'b0, 4'h8, 32'd0,          4'hF, 32'h0000_12AB};
    vecs[17] = '{1'b1, 4'h8, 32'd0,          4'hF, 32'd0};
    vecs[18] = '{1'b0, 4'h8, 32'd0,          4'hF, 32'd0};
    vecs[19] = '{1'b0, 4'hC, 32'd0,          4'hF, 32'd0};

    for (int i = 0; i < 20; i++) begin
      wb_rw(vecs[i].we, vecs[i].off, vecs[i].wdata, vecs[i].sel, rd);
      if (!vecs[i].we) check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // ---------------- address outside the window is never acked
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = BASE + 32'h10;
      repeat (4) begin
        @(posedge clk); #1;
        if (bus.wbs_ack_o) seen = 1'b1;
      end
      bus_idle();
      check("miss_no_ack", {31'd0, seen}, 32'd0);
    end

    // ---------------- overrun, drop count, W1C, seq/drop_since in status word
    do_reset();
    for (int f = 0; f < 3; f++) push_frame(32'h200 + 32'(f) * 32'h10, n);
    wb_read(4'h4, rd);  check("lvl27", rd, 32'd27);
    push_frame(32'h300, n);
    check("drop_no_stall", n, 0);
    wb_read(4'h4, rd);  check("ovr_status", rd, 32'h0001_001B);
    wb_read(4'hC, rd);  check("drop_cnt1", rd, 32'd1);
    wb_write(4'h4, 32'h0001_0000, 4'b0011);
    wb_read(4'h4, rd);  check("w1c_wrong_lane", rd, 32'h0001_001B);
    wb_write(4'h4, 32'h0001_0000, 4'b0100);
    wb_read(4'h4, rd);  check("w1c_clear", rd, 32'h0000_001B);
    wb_read(4'h0, rd);  check("f1_status", rd, 32'h0001_0008);
    for (int i = 0; i < 8; i++) wb_read(4'h0, rd);
    push_frame(32'h400, n);
    wb_read(4'h4, rd);  check("lvl27_again", rd, 32'd27);
    wb_read(4'h0, rd);  check("f2_status", rd, 32'h0002_0008);
    for (int i = 0; i < 17; i++) wb_read(4'h0, rd);
    wb_read(4'h0, rd);  check("f4_status", rd, 32'h0004_0108);
    wb_read(4'h0, rd);  check("f4_ch0", rd, 32'h400);

    // ---------------- watermark interrupt
    do_reset();
    wb_write(4'h8, 32'd9, 4'b0001);
    push_frame(32'h500, n);
    check("irq_not_early", {31'd0, bus.irq_o}, 32'd0);
    @(posedge clk); #1;
    check("irq_rise", {31'd0, bus.irq_o}, 32'd1);
    wb_read(4'h4, rd);  check("wm_status", rd, 32'h0002_0009);
    wb_read(4'h0, rd);  check("wm_pop", rd, 32'h0001_0008);
    check("irq_hold_at_pop", {31'd0, bus.irq_o}, 32'd1);
    @(posedge clk); #1;
    check("irq_clear", {31'd0, bus.irq_o}, 32'd0);

    // ---------------- flush at WRITE idx=4
    do_reset();
    @(negedge clk);
    bus.frame_valid = 1'b1;
    for (int k = 0; k < NUM_CH; k++) bus.frame_data[32*k +: 32] = 32'h600 + 32'(k);
    @(posedge clk); #1;
    bus.frame_valid = 1'b0;
    check("flush_taken", {31'd0, bus.frame_ready}, 32'd0);
    repeat (4) @(posedge clk);
    wb_write(4'h8, 32'h8000_0000, 4'b1000);
    check("flush_still_busy", {31'd0, bus.frame_ready}, 32'd0);
    @(posedge clk); #1;
    check("flush_ready", {31'd0, bus.frame_ready}, 32'd1);
    wb_read(4'h4, rd);  check("flush_status", rd, 32'd0);
    wb_read(4'h8, rd);  check("flush_reads0", rd, 32'd0);
    push_frame(32'h700, n);
    wb_read(4'h4, rd);  check("post_flush_lvl", rd, 32'd9);
    wb_read(4'h0, rd);  check("seq_skip", rd, 32'h0002_0008);

    // ---------------- wrap: pop while pushing 10 frames
    do_reset();
    got   = 0;
    tries = 0;
    fork
      begin
        int pn;
        for (int f = 1; f <= 10; f++) begin
          push_frame(32'hA000_0000 + 32'(f) * 32'h100, pn);
          repeat (10) @(posedge clk);
        end
      end
      begin
        logic [31:0] w;
        logic [31:0] ex;
        int          fr;
        int          wi;
        while (got < 90 && tries < 3000) begin
          wb_read(4'h0, w);
          tries++;
          if (w != 32'd0) begin
            fr = got / 9 + 1;
            wi = got % 9;
            if (wi == 0) ex = {16'(fr), 8'd0, 8'd8};
            else         ex = 32'hA000_0000 + 32'(fr) * 32'h100 + 32'(wi - 1);
            check($sformatf("wrap_word%0d", got), w, ex);
            got++;
          end
        end
      end
    join
    check("wrap_count", got, 90);
    wb_read(4'h4, rd);  check("wrap_status", rd, 32'd0);
    wb_read(4'hC, rd);  check("wrap_drops", rd, 32'd0);

    // ---------------- reset mid-WRITE
    wb_write(4'h8, 32'd5, 4'b0001);
    wb_read(4'h8, rd);  check("pre_rst_wm", rd, 32'd5);
    @(negedge clk);
    bus.frame_valid = 1'b1;
    for (int k = 0; k < NUM_CH; k++) bus.frame_data[32*k +: 32] = 32'h800 + 32'(k);
    @(posedge clk); #1;
    bus.frame_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, bus.frame_ready}, 32'd1);
    check("midrst_dat",   bus.wbs_dat_o,            32'd0);
    check("midrst_ack",   {31'd0, bus.wbs_ack_o},   32'd0);
    check("midrst_irq",   {31'd0, bus.irq_o},       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wb_read(4'h4, rd);  check("midrst_status", rd, 32'd0);
    wb_read(4'h8, rd);  check("midrst_wm", rd, 32'd0);
    push_frame(32'h900, n);
    wb_read(4'h0, rd);  check("midrst_seq", rd, 32'h0001_0008);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
